// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Shared pipeline constants and types for the fetch stage and the
// decode/control stage:
//   - next-PC select encodings (pcsrc)
//   - reset / interrupt / exception vectors
//   - bubble instruction value and the IF/ID payload struct
//   - small PC arithmetic helpers
// -----------------------------------------------------------------------------
package if_stage_pkg;

  // pcsrc encodings; 110 and 111 fall back to sequential fetch
  localparam logic [2:0] PCSRC_SEQ    = 3'b000;
  localparam logic [2:0] PCSRC_BRANCH = 3'b001;
  localparam logic [2:0] PCSRC_JUMP   = 3'b010;
  localparam logic [2:0] PCSRC_JR     = 3'b011;
  localparam logic [2:0] PCSRC_IRQ    = 3'b100;
  localparam logic [2:0] PCSRC_EXC    = 3'b101;

  // Fixed vectors; bit 31 set means supervisor mode
  localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
  localparam logic [31:0] IRQ_VECTOR   = 32'h8000_0004;
  localparam logic [31:0] EXC_VECTOR   = 32'h8000_0008;

  // Instruction word injected when IF/ID carries no real instruction
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

  // IF/ID payload
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcPlus4;
    logic        valid;
    logic        irq;
  } ifIdData_t;

  localparam ifIdData_t IFID_BUBBLE = '{
    instr:   BUBBLE_INSTR,
    pcPlus4: 32'h0000_0000,
    valid:   1'b0,
    irq:     1'b0
  };

  // Sequential increment: the carry out of bit 30 is dropped so that
  // straight-line code can never change the supervisor bit.
  function automatic logic [31:0] pcIncrement(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

  // PC-relative style redirects keep the current mode bit
  function automatic logic [31:0] keepMode(input logic modeBit, input logic [30:0] low);
    return {modeBit, low};
  endfunction

  // True when the selected source replaces sequential fetch
  function automatic logic isRedirect(input logic [2:0] pcsrc, input logic branchTaken);
    logic result;
    case (pcsrc)
      PCSRC_BRANCH: result = branchTaken;
      PCSRC_JUMP:   result = 1'b1;
      PCSRC_JR:     result = 1'b1;
      PCSRC_IRQ:    result = 1'b1;
      PCSRC_EXC:    result = 1'b1;
      default:      result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/if_stage_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register. Bubble has priority over stall, stall holds,
// otherwise the incoming payload is captured. Reset forces the bubble
// asynchronously.
// Ports:
//   clk, reset            clock, async active-high reset
//   stall                 hold current contents
//   bubble                load the bubble (wins over stall)
//   data                  payload captured when neither applies
//   ifid_instr/pc_plus4/valid/irq   registered outputs
// -----------------------------------------------------------------------------
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        bubble,
  input  ifIdData_t   data,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        ifid_irq
);

  ifIdData_t ifIdReg;

  // IF/ID register update: bubble > hold > capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifIdReg <= IFID_BUBBLE;
    end else if (bubble) begin
      ifIdReg <= IFID_BUBBLE;
    end else if (stall) begin
      ifIdReg <= ifIdReg;
    end else begin
      ifIdReg <= data;
    end
  end

  assign ifid_instr    = ifIdReg.instr;
  assign ifid_pc_plus4 = ifIdReg.pcPlus4;
  assign ifid_valid    = ifIdReg.valid;
  assign ifid_irq      = ifIdReg.irq;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction fetch stage: PC register, next-PC selection and the IF/ID
// register (instantiated as if_id_reg).
// Ports:
//   clk, reset                         clock, async active-high reset
//   stall                              load-use hold (PC and IF/ID)
//   flush                              bubble into IF/ID
//   pcsrc, branch_taken                next-PC select
//   branch_target, jump_target, jr_target   redirect addresses
//   irq                                level interrupt request
//   imem_addr                          fetch address (the PC register)
//   imem_rdata, imem_ready             combinational instruction read
//   ifid_instr/pc_plus4/valid/irq      registered IF/ID outputs
// -----------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [2:0]  pcsrc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  input  logic        irq,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        ifid_irq
);

  logic [31:0] pcReg;
  logic [31:0] pcPlus4;
  logic [31:0] redirectTarget;
  logic        redirect;
  logic [31:0] nextPc;
  logic        ifIdBubble;
  ifIdData_t   ifIdNext;

  // Branch and jump targets only supply bits [30:0]; their MSBs are ignored
  logic        unusedTargetMsbs;
  assign unusedTargetMsbs = branch_target[31] ^ jump_target[31];

  assign imem_addr = pcReg;
  assign pcPlus4   = pcIncrement(pcReg);
  assign redirect  = isRedirect(pcsrc, branch_taken);

  // Redirect target selection; only meaningful when redirect is set
  always_comb begin
    redirectTarget = pcPlus4;
    case (pcsrc)
      PCSRC_BRANCH: begin
        if (branch_taken) begin
          redirectTarget = keepMode(pcReg[31], branch_target[30:0]);
        end else begin
          redirectTarget = pcPlus4;
        end
      end
      PCSRC_JUMP: redirectTarget = keepMode(pcReg[31], jump_target[30:0]);
      PCSRC_JR:   redirectTarget = jr_target;
      PCSRC_IRQ:  redirectTarget = IRQ_VECTOR;
      PCSRC_EXC:  redirectTarget = EXC_VECTOR;
      default:    redirectTarget = pcPlus4;
    endcase
  end

  // Next PC: redirect > stall hold > not-ready hold > sequential
  always_comb begin
    nextPc = pcReg;
    if (redirect) begin
      nextPc = redirectTarget;
    end else if (stall) begin
      nextPc = pcReg;
    end else if (!imem_ready) begin
      nextPc = pcReg;
    end else begin
      nextPc = pcPlus4;
    end
  end

  // PC register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcReg <= RESET_VECTOR;
    end else begin
      pcReg <= nextPc;
    end
  end

  // A redirect squashes the instruction fetched down the wrong path; a
  // missing fetch only inserts a bubble when the stage is not stalled.
  // irq is sampled fresh every capture, so a request dropped by a bubble
  // reappears on the next real instruction while it stays high.
  always_comb begin
    ifIdBubble       = flush | redirect | (~stall & ~imem_ready);
    ifIdNext.instr   = imem_rdata;
    ifIdNext.pcPlus4 = pcPlus4;
    ifIdNext.valid   = 1'b1;
    ifIdNext.irq     = irq & ~pcReg[31];
  end

  if_id_reg u_if_id_reg (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .bubble        (ifIdBubble),
    .data          (ifIdNext),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid),
    .ifid_irq      (ifid_irq)
  );

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Directed test of if_stage with hand-computed expected values. The
// instruction memory is a fixed combinational function of the address so
// every expected instruction word follows from the expected PC.
// -----------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] MEM_KEY = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [2:0]  pcsrc;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic        irq;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        ifid_irq;

  int checkCount = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ MEM_KEY;

  if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .pcsrc         (pcsrc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .jr_target     (jr_target),
    .irq           (irq),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid),
    .ifid_irq      (ifid_irq)
  );

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return addr ^ MEM_KEY;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Full IF/ID snapshot check
  task automatic checkIfId(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                           input logic valid, input logic irqExp);
    checkValue({tag, ".instr"}, ifid_instr, instr);
    checkValue({tag, ".pc4"}, ifid_pc_plus4, pc4);
    checkValue({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, valid});
    checkValue({tag, ".irq"}, {31'd0, ifid_irq}, {31'd0, irqExp});
  endtask

  // One-cycle jr redirect to an arbitrary address, then back to sequential
  task automatic jumpTo(input logic [31:0] target);
    stall     = 1'b0;
    flush     = 1'b0;
    pcsrc     = 3'b011;
    jr_target = target;
    stepCycle();
    pcsrc     = 3'b000;
    checkValue("jr_setup", imem_addr, target);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got 0x00000000 expected 0x00000001");
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 1'b1;
    stall         = 1'b0;
    flush         = 1'b0;
    pcsrc         = 3'b000;
    branch_taken  = 1'b0;
    branch_target = 32'h0000_0000;
    jump_target   = 32'h0000_0000;
    jr_target     = 32'h0000_0000;
    irq           = 1'b0;
    imem_ready    = 1'b1;

    // Reset state
    #2;
    checkValue("rst_pc", imem_addr, 32'h8000_0000);
    checkIfId("rst_ifid", 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
    stepCycle();
    checkValue("rst_pc_clk", imem_addr, 32'h8000_0000);
    reset = 1'b0;

    // Sequential fetch after reset
    stepCycle();
    checkValue("seq_pc1", imem_addr, 32'h8000_0004);
    checkIfId("seq1", memWord(32'h8000_0000), 32'h8000_0004, 1'b1, 1'b0);
    stepCycle();
    checkValue("seq_pc2", imem_addr, 32'h8000_0008);
    checkIfId("seq2", memWord(32'h8000_0004), 32'h8000_0008, 1'b1, 1'b0);

    // Taken branch from 0x10
    jumpTo(32'h0000_0010);
    checkValue("jr_bubble", {31'd0, ifid_valid}, 32'd0);
    pcsrc = 3'b001; branch_taken = 1'b1; branch_target = 32'h0000_0040;
    stepCycle();
    checkValue("br_taken_pc", imem_addr, 32'h0000_0040);
    checkIfId("br_taken", 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);

    // Not-taken branch from 0x10
    jumpTo(32'h0000_0010);
    pcsrc = 3'b001; branch_taken = 1'b0;
    stepCycle();
    checkValue("br_nt_pc", imem_addr, 32'h0000_0014);
    checkIfId("br_nt", memWord(32'h0000_0010), 32'h0000_0014, 1'b1, 1'b0);

    // Branch target MSB replaced by current mode bit
    pcsrc = 3'b001; branch_taken = 1'b1; branch_target = 32'hFFFF_0040;
    stepCycle();
    checkValue("br_mode_pc", imem_addr, 32'h7FFF_0040);

    // Jump keeps mode bit (user mode), lands on 0x100
    pcsrc = 3'b010; jump_target = 32'h8000_0100; branch_taken = 1'b0;
    stepCycle();
    checkValue("jump_pc", imem_addr, 32'h0000_0100);
    checkValue("jump_bubble", {31'd0, ifid_valid}, 32'd0);

    // irq delivered in user mode
    pcsrc = 3'b000; irq = 1'b1;
    stepCycle();
    checkIfId("irq_user", memWord(32'h0000_0100), 32'h0000_0104, 1'b1, 1'b1);

    // irq masked in supervisor mode
    jumpTo(32'h8000_0100);
    checkValue("irq_redir_bubble", {31'd0, ifid_irq}, 32'd0);
    stepCycle();
    checkIfId("irq_sup", memWord(32'h8000_0100), 32'h8000_0104, 1'b1, 1'b0);
    irq = 1'b0;

    // Interrupt and exception vectors
    pcsrc = 3'b100;
    stepCycle();
    checkValue("irq_vec", imem_addr, 32'h8000_0004);
    pcsrc = 3'b101;
    stepCycle();
    checkValue("exc_vec", imem_addr, 32'h8000_0008);
    pcsrc = 3'b110;
    stepCycle();
    checkValue("pcsrc110_seq", imem_addr, 32'h8000_000C);
    pcsrc = 3'b111;
    stepCycle();
    checkValue("pcsrc111_seq", imem_addr, 32'h8000_0010);

    // Redirect + stall: redirect wins for PC, IF/ID bubble
    jumpTo(32'h0000_0020);
    stepCycle();
    checkValue("pre_stall_valid", {31'd0, ifid_valid}, 32'd1);
    jumpTo(32'h0000_0020);
    stall = 1'b1; pcsrc = 3'b011; jr_target = 32'h8000_1000;
    stepCycle();
    checkValue("redir_stall_pc", imem_addr, 32'h8000_1000);
    checkValue("redir_stall_valid", {31'd0, ifid_valid}, 32'd0);

    // Plain stall holds PC and IF/ID; flush+stall holds PC, bubbles IF/ID
    stall = 1'b0; pcsrc = 3'b000;
    stepCycle();
    stall = 1'b1;
    stepCycle();
    checkValue("stall_pc", imem_addr, 32'h8000_1004);
    checkIfId("stall_hold", memWord(32'h8000_1000), 32'h8000_1004, 1'b1, 1'b0);
    flush = 1'b1;
    stepCycle();
    checkValue("flush_stall_pc", imem_addr, 32'h8000_1004);
    checkValue("flush_stall_valid", {31'd0, ifid_valid}, 32'd0);
    stall = 1'b0; flush = 1'b0;

    // imem not ready: PC holds, bubbles; dropped irq re-presented later
    jumpTo(32'h0000_0008);
    imem_ready = 1'b0; irq = 1'b1;
    stepCycle();
    checkValue("nr1_pc", imem_addr, 32'h0000_0008);
    checkIfId("nr1", 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
    stepCycle();
    checkValue("nr2_pc", imem_addr, 32'h0000_0008);
    checkValue("nr2_valid", {31'd0, ifid_valid}, 32'd0);
    imem_ready = 1'b1;
    stepCycle();
    checkValue("ready_pc", imem_addr, 32'h0000_000C);
    checkIfId("ready", memWord(32'h0000_0008), 32'h0000_000C, 1'b1, 1'b1);
    irq = 1'b0;

    // Increment never carries into the mode bit
    jumpTo(32'h7FFF_FFFC);
    stepCycle();
    checkValue("wrap_user", imem_addr, 32'h0000_0000);
    jumpTo(32'hFFFF_FFFC);
    stepCycle();
    checkValue("wrap_sup", imem_addr, 32'h8000_0000);

    // Async reset mid-stall at 0x200 with a redirect pending
    jumpTo(32'h0000_01FC);
    stepCycle();
    checkValue("pre_rst_pc", imem_addr, 32'h0000_0200);
    stall = 1'b1;
    stepCycle();
    checkValue("pre_rst_stall_pc", imem_addr, 32'h0000_0200);
    checkValue("pre_rst_valid", {31'd0, ifid_valid}, 32'd1);
    #2;
    reset = 1'b1;
    pcsrc = 3'b011; jr_target = 32'h0000_0300;
    #1;
    checkValue("async_rst_pc", imem_addr, 32'h8000_0000);
    checkValue("async_rst_valid", {31'd0, ifid_valid}, 32'd0);
    stepCycle();
    reset = 1'b0; stall = 1'b0; pcsrc = 3'b000;
    checkValue("post_rst_pc", imem_addr, 32'h8000_0000);
    stepCycle();
    checkValue("post_rst_pc2", imem_addr, 32'h8000_0004);
    checkIfId("post_rst", memWord(32'h8000_0000), 32'h8000_0004, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have: clk  in  1  sole clock; all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: stall  in  1  load-use hold; freezes PC and IF/ID.
REQ-004 SHALL have: flush  in  1  replace IF/ID contents with a bubble.
REQ-005 SHALL have: pcsrc  in  3  next-PC select (000 seq, 001 branch, 010 j/jal, 011 jr/jalr, 100 interrupt, 101 exception, 110/111 seq).
REQ-006 SHALL have: branch_taken  in  1  qualifies pcsrc=001.
REQ-007 SHALL have: branch_target, jump_target, jr_target  in  32 each  redirect addresses.
REQ-008 SHALL have: irq  in  1  external interrupt request, level.
REQ-009 SHALL have: imem_addr  out  32  fetch address (= PC register).
REQ-010 SHALL have: imem_rdata  in  32  instruction, same-cycle combinational read.
REQ-011 SHALL have: imem_ready  in  1  imem_rdata valid this cycle.
REQ-012 SHALL have: ifid_instr  out  32, ifid_pc_plus4  out  32, ifid_valid  out  1, ifid_irq  out  1  registered IF/ID outputs.

Function
REQ-013 SHALL hold PC in one 32-bit register; imem_addr SHALL equal PC combinationally.
REQ-014 SHALL compute pc_plus4 = {PC[31], PC[30:0]+4}; carry out of bit 30 discarded, bit 31 (supervisor) preserved.
REQ-015 SHALL form next PC: 000/110/111 -> pc_plus4; 001 -> branch_taken ? {PC[31],branch_target[30:0]} : pc_plus4; 010 -> {PC[31],jump_target[30:0]}; 011 -> jr_target (all 32 bits); 100 -> 0x80000004; 101 -> 0x80000008.
REQ-016 SHALL treat "redirect" as pcsrc in {010,011,100,101}, or pcsrc=001 with branch_taken=1.
REQ-017 Per-cycle PC update priority SHALL be: redirect (load redirect target) > stall (hold) > imem_ready=0 (hold) > load pc_plus4.
REQ-018 IF/ID update priority SHALL be: flush or redirect -> bubble; else stall -> hold; else imem_ready=0 -> bubble; else capture imem_rdata, pc_plus4, valid=1, irq_masked.
REQ-019 Bubble SHALL be ifid_instr=0x00000000, ifid_pc_plus4=0x00000000, ifid_valid=0, ifid_irq=0.
REQ-020 irq_masked SHALL be irq AND NOT PC[31]; interrupts are never delivered in supervisor mode.
REQ-021 A dropped interrupt (irq high but bubble inserted) SHALL be re-presented on the next captured instruction while irq remains high; no internal latching of irq.
REQ-022 Redirect + stall in the same cycle: redirect SHALL win for PC; IF/ID SHALL receive bubble.
REQ-023 flush + stall without redirect: PC SHALL hold; IF/ID SHALL receive bubble.
REQ-024 Latency: instruction at PC appears on ifid_* one cycle after its fetch cycle with imem_ready=1.
REQ-025 No combinational path from pcsrc/targets to ifid_* outputs; all ifid_* SHALL be register outputs.

Reset
REQ-026 While reset=1, PC SHALL be 0x80000000 and IF/ID SHALL hold the bubble of REQ-019, asynchronously.
REQ-027 On reset deassertion, first fetch SHALL be from 0x80000000 at the next clk edge with imem_ready=1.
REQ-028 Reset asserted mid-stall or mid-redirect SHALL discard all pending state; no redirect survives reset.

Structure
REQ-029 pcsrc encodings, vectors 0x80000000/0x80000004/0x80000008, and the bubble instruction value SHALL be constants in the shared pipeline package used by the decode/control stage.
REQ-030 The IF/ID register SHALL be a sub-module if_id_reg (inputs: stall, bubble, data; outputs: ifid_*); next-PC selection stays in if_stage.

Verification
REQ-031 Reset, imem_ready=1, pcsrc=000 for 3 cycles -> imem_addr 0x80000000, 0x80000004, 0x80000008; ifid_pc_plus4 0x80000004 then 0x80000008, ifid_valid=1.
REQ-032 PC=0x00000010, pcsrc=001, branch_taken=1, branch_target=0x00000040 -> next imem_addr 0x00000040, IF/ID bubble; repeat with branch_taken=0 -> 0x00000014, valid instruction captured.
REQ-033 PC=0x00000020, stall=1 and pcsrc=011, jr_target=0x80001000 same cycle -> imem_addr 0x80001000, ifid_valid=0.
REQ-034 irq=1 at PC=0x00000100 -> ifid_irq=1; irq=1 at PC=0x80000100 -> ifid_irq=0; pcsrc=100 -> imem_addr 0x80000004.
REQ-035 imem_ready=0 for 2 cycles at PC=0x00000008 -> imem_addr stays 0x00000008, two bubbles; ready=1 -> instruction captured, PC 0x0000000C.
REQ-036 reset pulsed asynchronously mid-stall at PC=0x00000200 -> PC=0x80000000 and ifid_valid=0 immediately, before next clk edge.
